// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, bus field
// layouts, load-type codes, FSM encoding and small load-shaping helpers.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 130;
  localparam int MS_TO_WS_BUS_WD = 123;
  localparam int MS_TO_DS_BUS_WD = 42;

  // Bit of c0_bus that marks an eret instruction
  localparam int C0_ERET_BIT = 10;

  // Load-type codes carried in load_op
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  // Memory-response tracking states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ms_state_e;

  // EX -> MEM bus, MSB first
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic        mem_re;
    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
    logic        req;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  // MEM -> WB bus, MSB first
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // MEM -> ID forwarding bus, MSB first
  typedef struct packed {
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        load_pending;
  } ms_to_ds_t;

  // Extend a byte to a word, signed or unsigned
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic fill;
    fill = sgn & b[7];
    return {{24{fill}}, b};
  endfunction

  // Extend a halfword to a word, signed or unsigned
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic fill;
    fill = sgn & h[15];
    return {{16{fill}}, h};
  endfunction

  // Register byte enables for lwl: upper bytes written, count grows with addr_lo
  function automatic logic [3:0] lwl_we(input logic [1:0] addr_lo);
    logic [3:0] we;
    case (addr_lo)
      2'd0:    we = 4'b1000;
      2'd1:    we = 4'b1100;
      2'd2:    we = 4'b1110;
      2'd3:    we = 4'b1111;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  // Register byte enables for lwr: lower bytes written, count shrinks with addr_lo
  function automatic logic [3:0] lwr_we(input logic [1:0] addr_lo);
    logic [3:0] we;
    case (addr_lo)
      2'd0:    we = 4'b1111;
      2'd1:    we = 4'b0111;
      2'd2:    we = 4'b0011;
      2'd3:    we = 4'b0001;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load data extraction: picks the byte/half lane selected by
// the low address bits, extends it, and produces register byte enables.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [3:0]  load_we
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [1:0]  lwl_sh_s;

  // Select the addressed byte lane
  always_comb begin
    byte_s = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
  end

  // Select the addressed halfword lane and the lwl shift amount in bytes
  always_comb begin
    half_s   = rdata[15:0];
    lwl_sh_s = 2'd3 - addr_lo;
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Shape the word and byte enables according to the load type
  always_comb begin
    load_data = rdata;
    load_we   = 4'b1111;
    case (load_op)
      LD_LW:  load_data = rdata;
      LD_LB:  load_data = ext_byte(byte_s, 1'b1);
      LD_LBU: load_data = ext_byte(byte_s, 1'b0);
      LD_LH:  load_data = ext_half(half_s, 1'b1);
      LD_LHU: load_data = ext_half(half_s, 1'b0);
      LD_LWL: begin
        load_data = rdata << {lwl_sh_s, 3'b000};
        load_we   = lwl_we(addr_lo);
      end
      LD_LWR: begin
        load_data = rdata >> {addr_lo, 3'b000};
        load_we   = lwr_we(addr_lo);
      end
      default: begin
        load_data = rdata;
        load_we   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM
// response, buffers the read data when WB stalls, discards responses that
// belong to flushed requests, and forwards results to WB and ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  input  logic                       es_req_killed,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex_or_eret
);

  es_to_ms_t   es_in_s;
  es_to_ms_t   es_bus_q, es_bus_d;
  logic        ms_valid_q, ms_valid_d;
  ms_state_e   state_q, state_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;
  logic [31:0] hold_data_q, hold_data_d;

  logic        counted_ok_s;
  logic        drop_ok_s;
  logic        flush_pend_s;
  logic [2:0]  discard_sum_s;
  logic        ready_go_s;
  logic        load_en_s;
  logic [31:0] rdata_src_s;
  logic [31:0] load_data_s;
  logic [3:0]  load_we_s;
  ms_to_ws_t   ws_bus_s;
  ms_to_ds_t   ds_bus_s;

  assign es_in_s = es_to_ms_bus;

  // Pipeline handshake: when this stage may finish and accept a new entry
  always_comb begin
    counted_ok_s = data_sram_data_ok & (discard_cnt_q == 2'd0);
    ready_go_s   = 1'b0;
    case (state_q)
      ST_IDLE: ready_go_s = ~es_bus_q.req;
      ST_WAIT: ready_go_s = counted_ok_s;
      ST_HOLD: ready_go_s = 1'b1;
      default: ready_go_s = 1'b0;
    endcase
    ms_allowin     = ~ms_valid_q | (ready_go_s & ws_allowin);
    ms_to_ws_valid = ms_valid_q & ready_go_s & ~flush;
    load_en_s      = es_to_ms_valid & ms_allowin;
  end

  // Response FSM next state; flush wins, a newly loaded entry restarts tracking
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (load_en_s) begin
      state_d = es_in_s.req ? ST_WAIT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT: begin
          if (counted_ok_s) begin
            state_d = ws_allowin ? ST_IDLE : ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (ws_allowin) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Valid bit, entry payload and held read data
  always_comb begin
    ms_valid_d  = ms_valid_q;
    es_bus_d    = es_bus_q;
    hold_data_d = hold_data_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end else begin
      ms_valid_d = ms_valid_q;
    end
    if (load_en_s) begin
      es_bus_d = es_in_s;
    end else begin
      es_bus_d = es_bus_q;
    end
    if ((state_q == ST_WAIT) && counted_ok_s && !ws_allowin) begin
      hold_data_d = data_sram_rdata;
    end else begin
      hold_data_d = hold_data_q;
    end
  end

  // Outstanding responses to throw away. A flush in WAIT only orphans our
  // request if its own response is not arriving this cycle; a stale response
  // landing with the flush does not count as ours.
  always_comb begin
    flush_pend_s  = flush & (state_q == ST_WAIT) & ~counted_ok_s;
    drop_ok_s     = data_sram_data_ok & (discard_cnt_q != 2'd0);
    discard_sum_s = {1'b0, discard_cnt_q} + {2'b00, flush_pend_s}
                  + {2'b00, es_req_killed} - {2'b00, drop_ok_s};
    if (discard_sum_s > 3'd3) begin
      discard_cnt_d = 2'd3;
    end else begin
      discard_cnt_d = discard_sum_s[1:0];
    end
  end

  // Read data comes straight from the SRAM unless it was parked in HOLD
  always_comb begin
    if (state_q == ST_HOLD) begin
      rdata_src_s = hold_data_q;
    end else begin
      rdata_src_s = data_sram_rdata;
    end
  end

  mem_load_align u_load_align (
    .load_op   (es_bus_q.load_op),
    .addr_lo   (es_bus_q.addr_lo),
    .rdata     (rdata_src_s),
    .load_data (load_data_s),
    .load_we   (load_we_s)
  );

  // Assemble WB and forwarding buses
  always_comb begin
    ws_bus_s.badvaddr = es_bus_q.badvaddr;
    ws_bus_s.c0_bus   = es_bus_q.c0_bus;
    ws_bus_s.bd       = es_bus_q.bd;
    ws_bus_s.ex       = es_bus_q.ex;
    ws_bus_s.excode   = es_bus_q.excode;
    ws_bus_s.dest     = es_bus_q.dest;
    ws_bus_s.pc       = es_bus_q.pc;
    if (es_bus_q.mem_re) begin
      ws_bus_s.final_result = load_data_s;
    end else begin
      ws_bus_s.final_result = es_bus_q.result;
    end
    if (es_bus_q.ex) begin
      ws_bus_s.rf_we = 4'b0000;
    end else if (es_bus_q.mem_re) begin
      ws_bus_s.rf_we = load_we_s;
    end else begin
      ws_bus_s.rf_we = es_bus_q.rf_we;
    end

    if (ms_valid_q) begin
      ds_bus_s.rf_we = ws_bus_s.rf_we;
    end else begin
      ds_bus_s.rf_we = 4'b0000;
    end
    ds_bus_s.dest         = es_bus_q.dest;
    ds_bus_s.data         = ws_bus_s.final_result;
    ds_bus_s.load_pending = ms_valid_q & es_bus_q.mem_re & ~ready_go_s;

    ms_to_ws_bus  = ws_bus_s;
    ms_to_ds_bus  = ds_bus_s;
    ms_ex_or_eret = ms_valid_q & (es_bus_q.ex | es_bus_q.c0_bus[C0_ERET_BIT]);
  end

  // State registers; reset abandons any request in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      es_bus_q      <= '0;
      state_q       <= ST_IDLE;
      discard_cnt_q <= 2'd0;
      hold_data_q   <= 32'd0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      es_bus_q      <= es_bus_d;
      state_q       <= state_d;
      discard_cnt_q <= discard_cnt_d;
      hold_data_q   <= hold_data_d;
    end
  end

endmodule
